// File: rtl/sequential_digit_subtractor.sv
// Digit-serial subtractor: d = a - b - borrow_in, one W-bit digit per clock.
// Optional signed overflow flag is built when SUB_SIGNED_OVERFLOW_EN is defined.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready, a, b,
//   borrow_in                     operand handshake and operands
//   out_valid/out_ready, d,
//   borrow_out, overflow          result handshake and result
module sequential_digit_subtractor #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         borrow_out,
    output logic         overflow
);

    localparam int D  = N / W;
    localparam int KW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [KW-1:0] k;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  d_q;
    logic          br_q;
    logic          bo_q;
    logic          rdy_q;
    logic [W-1:0]  a_dig;
    logic [W-1:0]  b_dig;
    logic [W:0]    diff;
    logic          last;

    assign a_dig = a_q[k*W +: W];
    assign b_dig = b_q[k*W +: W];

    // Extra MSB of the widened difference is the digit borrow-out.
    assign diff = {1'b0, a_dig} - {1'b0, b_dig} - {{W{1'b0}}, br_q};
    assign last = (k == KW'(D - 1));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (in_valid && rdy_q) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rdy_q <= 1'b0;
            k     <= '0;
            a_q   <= '0;
            b_q   <= '0;
            d_q   <= '0;
            br_q  <= 1'b0;
            bo_q  <= 1'b0;
        end else begin
            state <= state_n;
            // Ready is registered so it never depends on inputs directly.
            rdy_q <= (state_n == IDLE);
            unique case (state)
                IDLE: begin
                    if (in_valid && rdy_q) begin
                        a_q  <= a;
                        b_q  <= b;
                        br_q <= borrow_in;
                        k    <= '0;
                    end
                end
                RUN: begin
                    d_q[k*W +: W] <= diff[W-1:0];
                    br_q          <= diff[W];
                    k             <= k + KW'(1);
                    if (last) bo_q <= diff[W];
                end
                default: ;
            endcase
        end
    end

`ifdef SUB_SIGNED_OVERFLOW_EN
    logic msb_br_q;

    // Borrow into bit N-1 recovered as a ^ b ^ d at the top bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            msb_br_q <= 1'b0;
        end else if (state == RUN && last) begin
            msb_br_q <= a_dig[W-1] ^ b_dig[W-1] ^ diff[W-1];
        end
    end

    assign overflow = msb_br_q ^ bo_q;
`else
    assign overflow = 1'b0;
`endif

    assign in_ready   = rdy_q;
    assign out_valid  = (state == DONE);
    assign d          = d_q;
    assign borrow_out = bo_q;

endmodule

// File: tb/tb_sequential_digit_subtractor.sv
// Scoreboard testbench for sequential_digit_subtractor (N=32, W=8).
// Expected results are computed at acceptance and compared on output.
module tb_sequential_digit_subtractor;

    localparam int N = 32;
    localparam int W = 8;
    localparam int LAT = N / W;

    typedef struct {
        logic [N-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] d;
    logic         borrow_out;
    logic         overflow;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    sequential_digit_subtractor #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .d          (d),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] x,
                                   input logic [N-1:0] y,
                                   input logic bi);
        exp_t e;
        logic [N:0]   u;
        logic [N+1:0] s;
        u = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bi};
        s = {{2{x[N-1]}}, x} - {{2{y[N-1]}}, y} - {{(N+1){1'b0}}, bi};
        e.d  = u[N-1:0];
        e.bo = u[N];
`ifdef SUB_SIGNED_OVERFLOW_EN
        e.ov = (s[N+1:N-1] != 3'b000) && (s[N+1:N-1] != 3'b111);
`else
        e.ov = 1'b0;
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic bi, input bit push);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        borrow_in = bi;
        tick();
        in_valid  = 1'b0;
        a         = $urandom;
        b         = $urandom;
        borrow_in = 1'($urandom);
        if (push) sb.push_back(model(x, y, bi));
    endtask

    task automatic recv(input string tag, input bit chk_lat);
        int   lat;
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        if (chk_lat) chk({tag, "_lat"}, 64'(lat), 64'(LAT));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_d"}, 64'(d), 64'(e.d));
        chk({tag, "_bo"}, 64'(borrow_out), 64'(e.bo));
        chk({tag, "_ov"}, 64'(overflow), 64'(e.ov));
        tick();
        chk({tag, "_vld_clr"}, 64'(out_valid), 0);
    endtask

    initial begin
        exp_t e;
        int   seen;

        tick();
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_d", 64'(d), 0);
        chk("rst_bo", 64'(borrow_out), 0);
        chk("rst_ov", 64'(overflow), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 64'(in_ready), 1);

        send(32'h0000_0005, 32'h3, 1'b0, 1);
        recv("basic", 1);
        send(32'h0, 32'h1, 1'b0, 1);
        recv("underflow", 1);
        send(32'h8000_0000, 32'h1, 1'b0, 1);
        recv("sovf", 1);
        send(32'h0000_0100, 32'h0, 1'b1, 1);
        recv("digit_borrow", 1);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1);
        recv("sovf_pos", 1);
        send(32'h1234_5678, 32'h1234_5678, 1'b1, 1);
        recv("eq_bin", 1);
        for (int i = 0; i < 8; i++) begin
            send($urandom, $urandom, 1'($urandom), 1);
            recv("rand", 1);
        end

        // Backpressure with new operands offered during DONE.
        out_ready = 1'b0;
        send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1);
        seen = 0;
        while (!out_valid && seen < 50) begin
            tick();
            seen++;
        end
        chk("bp_lat", 64'(seen), 64'(LAT));
        e = sb[0];
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            tick();
            chk("bp_valid", 64'(out_valid), 1);
            chk("bp_in_ready", 64'(in_ready), 0);
            chk("bp_d", 64'(d), 64'(e.d));
            chk("bp_bo", 64'(borrow_out), 64'(e.bo));
        end
        out_ready = 1'b1;
        a         = 32'h0000_1000;
        b         = 32'h0000_0001;
        borrow_in = 1'b0;
        void'(sb.pop_front());
        tick();
        chk("bp_hs_valid", 64'(out_valid), 0);
        chk("bp_hs_ready", 64'(in_ready), 1);
        sb.push_back(model(32'h0000_1000, 32'h1, 1'b0));
        tick();
        in_valid = 1'b0;
        recv("bp_next", 1);

        // Reset after two digits of a RUN.
        send(32'h5555_5555, 32'h1111_1111, 1'b0, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", 64'(out_valid), 0);
        chk("mrst_ready", 64'(in_ready), 0);
        chk("mrst_d", 64'(d), 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("mrst_no_valid", 64'(seen), 0);
        chk("mrst_idle_ready", 64'(in_ready), 1);
        send(32'd10, 32'd4, 1'b0, 1);
        recv("after_rst", 1);

        chk("sb_drained", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
